// File: rtl/hilo_commit.sv
// HI/LO write-back path: carries EX HI/LO write requests through the EX/MEM and
// MEM/WB latches, then commits them to the architectural HI/LO pair.
module hilo_commit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_whilo_i,
    input  logic [DATA_W-1:0] ex_hi_i,
    input  logic [DATA_W-1:0] ex_lo_i,
    input  logic [2:0]        stall_i,
    input  logic              flush_i,
    output logic              mem_whilo_o,
    output logic [DATA_W-1:0] mem_hi_o,
    output logic [DATA_W-1:0] mem_lo_o,
    output logic              wb_whilo_o,
    output logic [DATA_W-1:0] wb_hi_o,
    output logic [DATA_W-1:0] wb_lo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [7:0]        commit_cnt_o
);

    logic              r_mem_whilo, r_wb_whilo;
    logic [DATA_W-1:0] r_mem_hi, r_mem_lo, r_wb_hi, r_wb_lo, r_hi, r_lo;
    logic [7:0]        r_cnt;

    logic w_mem_clr, w_mem_load, w_wb_clr, w_wb_load;

    // A stage stalled while its successor runs must hand on a bubble.
    assign w_mem_clr  = flush_i | (stall_i[0] & ~stall_i[1]);
    assign w_mem_load = ~stall_i[0];
    assign w_wb_clr   = flush_i | (stall_i[1] & ~stall_i[2]);
    assign w_wb_load  = ~stall_i[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_whilo <= 1'b0;
            r_mem_hi    <= '0;
            r_mem_lo    <= '0;
            r_wb_whilo  <= 1'b0;
            r_wb_hi     <= '0;
            r_wb_lo     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_cnt       <= 8'd0;
        end else begin
            // The MEM/WB entry is past the exception point, so it commits even on flush or WB stall.
            if (r_wb_whilo) begin
                r_hi  <= r_wb_hi;
                r_lo  <= r_wb_lo;
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_mem_clr) begin
                r_mem_whilo <= 1'b0;
                r_mem_hi    <= '0;
                r_mem_lo    <= '0;
            end else if (w_mem_load) begin
                r_mem_whilo <= ex_whilo_i;
                r_mem_hi    <= ex_hi_i;
                r_mem_lo    <= ex_lo_i;
            end

            if (w_wb_clr) begin
                r_wb_whilo <= 1'b0;
                r_wb_hi    <= '0;
                r_wb_lo    <= '0;
            end else if (w_wb_load) begin
                r_wb_whilo <= r_mem_whilo;
                r_wb_hi    <= r_mem_hi;
                r_wb_lo    <= r_mem_lo;
            end
        end
    end

    assign mem_whilo_o  = r_mem_whilo;
    assign mem_hi_o     = r_mem_hi;
    assign mem_lo_o     = r_mem_lo;
    assign wb_whilo_o   = r_wb_whilo;
    assign wb_hi_o      = r_wb_hi;
    assign wb_lo_o      = r_wb_lo;
    assign hi_o         = r_hi;
    assign lo_o         = r_lo;
    assign commit_cnt_o = r_cnt;

endmodule

// File: tb/tb_hilo_commit.sv
// Randomized and directed bench for hilo_commit against a transaction-level
// model of the two pipeline slots and the committed HI/LO state.
module tb_hilo_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_whilo_i;
    logic [31:0] ex_hi_i, ex_lo_i;
    logic [2:0]  stall_i;
    logic        flush_i;
    logic        mem_whilo_o, wb_whilo_o;
    logic [31:0] mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o, hi_o, lo_o;
    logic [7:0]  commit_cnt_o;

    hilo_commit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ex_whilo_i(ex_whilo_i), .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .mem_whilo_o(mem_whilo_o), .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o),
        .wb_whilo_o(wb_whilo_o), .wb_hi_o(wb_hi_o), .wb_lo_o(wb_lo_o),
        .hi_o(hi_o), .lo_o(lo_o), .commit_cnt_o(commit_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [31:0] hi;
        logic [31:0] lo;
    } req_t;

    // Model: slot[0] = request in MEM, slot[1] = request in WB.
    req_t        slot [2];
    logic [31:0] m_hi, m_lo;
    int          m_commits;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic w, input logic [31:0] h, input logic [31:0] l,
                              input logic [2:0] st, input logic fl, input logic r);
        req_t empty, nxt_mem, nxt_wb;
        empty = '{v: 1'b0, hi: 32'd0, lo: 32'd0};
        if (r) begin
            slot[0] = empty; slot[1] = empty;
            m_hi = 0; m_lo = 0; m_commits = 0;
            return;
        end
        if (slot[1].v) begin
            m_hi = slot[1].hi; m_lo = slot[1].lo; m_commits++;
        end
        // A slot advances when its stage runs, holds when its successor is also
        // stalled, and otherwise becomes empty; flush empties both slots.
        if (fl)          nxt_wb = empty;
        else if (!st[1]) nxt_wb = slot[0];
        else             nxt_wb = st[2] ? slot[1] : empty;
        if (fl)          nxt_mem = empty;
        else if (!st[0]) nxt_mem = '{v: w, hi: h, lo: l};
        else             nxt_mem = st[1] ? slot[0] : empty;
        slot[0] = nxt_mem;
        slot[1] = nxt_wb;
    endtask

    task automatic compare_all();
        chk("mem_whilo", {31'd0, mem_whilo_o}, {31'd0, slot[0].v});
        chk("mem_hi", mem_hi_o, slot[0].hi);
        chk("mem_lo", mem_lo_o, slot[0].lo);
        chk("wb_whilo", {31'd0, wb_whilo_o}, {31'd0, slot[1].v});
        chk("wb_hi", wb_hi_o, slot[1].hi);
        chk("wb_lo", wb_lo_o, slot[1].lo);
        chk("hi", hi_o, m_hi);
        chk("lo", lo_o, m_lo);
        chk("commit_cnt", {24'd0, commit_cnt_o}, m_commits % 256);
    endtask

    task automatic step(input logic w, input logic [31:0] h, input logic [31:0] l,
                        input logic [2:0] st, input logic fl, input logic r);
        ex_whilo_i = w; ex_hi_i = h; ex_lo_i = l;
        stall_i = st; flush_i = fl; rst = r;
        @(posedge clk);
        model_edge(w, h, l, st, fl, r);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [2:0] st;
        logic       w, fl, r;
        int         pick;

        ex_whilo_i = 0; ex_hi_i = 0; ex_lo_i = 0; stall_i = 0; flush_i = 0; rst = 1;
        slot[0] = '{v: 1'b0, hi: 32'd0, lo: 32'd0};
        slot[1] = slot[0];
        m_hi = 0; m_lo = 0; m_commits = 0;

        // Reset
        step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 1'b0, 1'b1);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_cnt", {24'd0, commit_cnt_o}, 32'd0);

        // Single write: MEM after edge 1, WB after edge 2, architectural after edge 3
        step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 1'b0, 1'b0);
        chk("single_mem_v", {31'd0, mem_whilo_o}, 32'd1);
        idle(1);
        chk("single_wb_v", {31'd0, wb_whilo_o}, 32'd1);
        idle(1);
        chk("single_hi", hi_o, 32'h1234_5678);
        chk("single_lo", lo_o, 32'h9ABC_DEF0);
        chk("single_cnt", {24'd0, commit_cnt_o}, 32'd1);

        // Back-to-back
        step(1'b1, 32'd1, 32'd2, 3'b000, 1'b0, 1'b0);
        step(1'b1, 32'd3, 32'd4, 3'b000, 1'b0, 1'b0);
        chk("b2b_mem_hi", mem_hi_o, 32'd3);
        chk("b2b_wb_hi", wb_hi_o, 32'd1);
        idle(2);
        chk("b2b_hi", hi_o, 32'd3);
        chk("b2b_lo", lo_o, 32'd4);
        chk("b2b_cnt", {24'd0, commit_cnt_o}, 32'd3);

        // EX stall bubble, then the request flows once released
        step(1'b1, 32'hB0, 32'hB1, 3'b001, 1'b0, 1'b0);
        chk("bubble_mem_v", {31'd0, mem_whilo_o}, 32'd0);
        step(1'b1, 32'hB0, 32'hB1, 3'b000, 1'b0, 1'b0);
        idle(2);
        chk("bubble_hi", hi_o, 32'hB0);

        // MEM+EX stall hold for 3 cycles
        step(1'b1, 32'hC, 32'hC1, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'hDEAD, 32'hBEEF, 3'b011, 1'b0, 1'b0);
            chk("hold_mem_hi", mem_hi_o, 32'hC);
            chk("hold_wb_v", {31'd0, wb_whilo_o}, 32'd0);
        end
        idle(2);
        chk("hold_commit_hi", hi_o, 32'hC);

        // Flush: E in MEM/WB commits, D in EX/MEM is discarded
        step(1'b1, 32'hE, 32'hE1, 3'b000, 1'b0, 1'b0);
        step(1'b1, 32'hD, 32'hD1, 3'b000, 1'b0, 1'b0);
        pick = commit_cnt_o;
        step(1'b1, 32'h77, 32'h78, 3'b000, 1'b1, 1'b0);
        chk("flush_hi", hi_o, 32'hE);
        chk("flush_mem_v", {31'd0, mem_whilo_o}, 32'd0);
        chk("flush_wb_v", {31'd0, wb_whilo_o}, 32'd0);
        chk("flush_cnt", {24'd0, commit_cnt_o}, (pick + 1) % 256);
        idle(2);
        chk("flush_d_dropped", hi_o, 32'hE);

        // Reset mid-flight
        step(1'b1, 32'h51, 32'h52, 3'b000, 1'b0, 1'b0);
        step(1'b1, 32'h53, 32'h54, 3'b000, 1'b0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 1'b1);
        chk("midrst_hi", hi_o, 32'd0);
        chk("midrst_cnt", {24'd0, commit_cnt_o}, 32'd0);
        idle(2);
        chk("midrst_nocommit", hi_o, 32'd0);

        // Random traffic; WB stall is only raised with the WB slot empty
        for (int i = 0; i < 600; i++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1:    st = 3'b001;
                2, 3:    st = 3'b011;
                4:       st = slot[1].v ? 3'b011 : 3'b111;
                default: st = 3'b000;
            endcase
            w  = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(w, $urandom, $urandom, st, fl, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
